// File: rtl/bcd_dec.sv
// bcd_dec: registered BCD digit to ten-line one-hot decoder with illegal-code
// flag. Output polarity and the reset pattern are selected by parameters;
// err and o_vld are always active-high.
module bcd_dec #(
    parameter int ACTIVE_LOW     = 0,
    parameter int RESET_DIGIT_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] i,
    input  logic       i_vld,
    output logic [0:9] o,
    output logic       o_vld,
    output logic       err
);

    // Active-high reset pattern: either no line selected or digit 0 selected.
    localparam logic [0:9] HOT_RST = (RESET_DIGIT_EN != 0) ? 10'b1000000000 : 10'b0000000000;
    // XOR mask applied to the active-high pattern to obtain the bus polarity.
    localparam logic [0:9] POL     = (ACTIVE_LOW != 0) ? 10'b1111111111 : 10'b0000000000;

    logic [0:9] dec;
    logic       illegal;

    // Decode the digit: line d is the (9-d)th bit of the vector, so a right
    // shift of the MSB-only pattern selects it; codes 10..15 select nothing.
    always_comb begin
        dec     = '0;
        illegal = (i > 4'd9);
        if (!illegal) begin
            dec = 10'b1000000000 >> i;
        end
    end

    // Output register: reset wins over an accepted digit; idle cycles hold o/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            o     <= HOT_RST ^ POL;
            o_vld <= 1'b0;
            err   <= 1'b0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                o   <= dec ^ POL;
                err <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_bcd_dec.sv
// tb_bcd_dec: self-checking bench for bcd_dec. Two instances (default
// parameters and ACTIVE_LOW=1/RESET_DIGIT_EN=1) share the same stimulus and
// are compared every cycle against a behavioural digit model.
module tb_bcd_dec;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] i;
    logic       i_vld;

    logic [0:9] o_a, o_b;
    logic       vld_a, vld_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_dec #(.ACTIVE_LOW(0), .RESET_DIGIT_EN(0)) dut_a (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld),
        .o(o_a), .o_vld(vld_a), .err(err_a)
    );

    bcd_dec #(.ACTIVE_LOW(1), .RESET_DIGIT_EN(1)) dut_b (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld),
        .o(o_b), .o_vld(vld_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Expected bus for a decoded digit: digit d lights o[d], which is the
    // value 2^(9-d) because o[0] is the leftmost bit; none for d > 9.
    function automatic logic [9:0] expect_bus(int d, bit active_low);
        logic [9:0] v;
        if (d > 9) v = 10'd0;
        else       v = 10'(2 ** (9 - d));
        return active_low ? ~v : v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: remembers the last accepted digit (or reset state).
    bit       model_ok = 1'b0;
    int       last_d;           // -1 = reset with no line, else digit value
    bit       exp_vld;
    bit       exp_err;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            model_ok = 1'b1;
            last_d   = -1;
            exp_vld  = 1'b0;
            exp_err  = 1'b0;
        end else if (i_vld === 1'b1) begin
            last_d  = int'(i);
            exp_vld = 1'b1;
            exp_err = (int'(i) > 9);
        end else begin
            exp_vld = 1'b0;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("o_a",   32'(o_a),   32'(last_d < 0 ? 10'd0 : expect_bus(last_d, 1'b0)));
            chk("o_b",   32'(o_b),   32'(last_d < 0 ? expect_bus(0, 1'b1) : expect_bus(last_d, 1'b1)));
            chk("vld_a", 32'(vld_a), 32'(exp_vld));
            chk("vld_b", 32'(vld_b), 32'(exp_vld));
            chk("err_a", 32'(err_a), 32'(exp_err));
            chk("err_b", 32'(err_b), 32'(exp_err));
        end
    end

    // Apply inputs, then wait until the edge has consumed them (next negedge).
    task automatic drive(bit r, bit v, int d);
        rst   = r;
        i_vld = v;
        i     = 4'(d);
        @(negedge clk);
    endtask

    initial begin
        // Reset held two cycles with a competing valid digit.
        drive(1, 1, 5);
        drive(1, 1, 5);
        chk("rst_o",     32'(o_a),   32'(10'b0000000000));
        chk("rst_err",   32'(err_a), 32'd0);
        chk("rst_vld",   32'(vld_a), 32'd0);
        chk("rst_o_var", 32'(o_b),   32'(10'b0111111111));

        // Back-to-back sweep 0..9.
        for (int d = 0; d < 10; d++) begin
            drive(0, 1, d);
            if (d == 0) begin
                chk("sweep0",     32'(o_a), 32'(10'b1000000000));
                chk("sweep0_var", 32'(o_b), 32'(10'b0111111111));
            end
            if (d == 9) chk("sweep9", 32'(o_a), 32'(10'b0000000001));
            chk("sweep_vld", 32'(vld_a), 32'd1);
        end

        // Illegal codes, then a legal digit clears err.
        for (int d = 10; d < 16; d++) begin
            drive(0, 1, d);
            chk("ill_o",   32'(o_a),   32'(10'b0000000000));
            chk("ill_err", 32'(err_a), 32'd1);
        end
        drive(0, 1, 3);
        chk("after_ill_o",   32'(o_a),   32'(10'b0001000000));
        chk("after_ill_err", 32'(err_a), 32'd0);

        // Hold with i changing while idle.
        drive(0, 1, 7);
        drive(0, 0, 2);
        chk("hold_o",   32'(o_a),   32'(10'b0000000100));
        chk("hold_vld", 32'(vld_a), 32'd0);

        // Reset in the middle of a stream discards the concurrent digit.
        drive(0, 1, 4);
        drive(1, 1, 8);
        chk("mid_rst_o",   32'(o_a),   32'(10'b0000000000));
        chk("mid_rst_vld", 32'(vld_a), 32'd0);
        drive(0, 1, 8);
        chk("post_rst_o", 32'(o_a), 32'(10'b0000000010));

        // Randomised traffic; i is driven unknown while idle.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) < 4);
            i_vld = ($urandom_range(0, 99) < 70);
            if (i_vld) i = 4'($urandom_range(0, 15));
            else       i = 'x;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
